// File: rtl/rr_arb_mux_pkg.sv
// rr_arb_mux_pkg: shared constants, mode encodings and width helpers for the arbitrating mux.
package rr_arb_mux_pkg;

    localparam int   DEF_WIDTH  = 8;
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

    // A one-channel index still needs one bit.
    function automatic int sel_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first requester at or above ptr, wrapping N-1 -> 0.
module rr_arbiter
    import rr_arb_mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int SEL_W = sel_width(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [SEL_W-1:0] idx_o,
    output logic             any_o
);

    logic [SEL_W-1:0] c;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        c     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            c = SEL_W'((int'(ptr_i) + k) % N);
            if (req_i[c]) begin
                idx_o = c;
                any_o = 1'b1;
            end
        end
        grant_o = any_o ? (N'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-to-1 mux with fixed-select or round-robin arbitration into a one-slot output register.
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter  int WIDTH  = DEF_WIDTH,
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = sel_width(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode_i,
    input  logic [SEL_W-1:0]        sel_i,
    input  logic [NUM_IN*WIDTH-1:0] in_data_i,
    input  logic [NUM_IN-1:0]       in_valid_i,
    output logic [NUM_IN-1:0]       in_ready_o,
    output logic [WIDTH-1:0]        out_data_o,
    output logic [SEL_W-1:0]        out_src_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i
);

    logic [SEL_W-1:0]  ptr_q, ptr_d, fix_sel, rr_idx, g;
    logic [NUM_IN-1:0] rr_grant;
    logic              rr_any, is_rr, has_grant, load;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_src_q, out_src_d;
    logic              out_valid_q, out_valid_d;

    rr_arbiter #(.N(NUM_IN), .SEL_W(SEL_W)) u_arb (
        .req_i   (in_valid_i),
        .ptr_i   (ptr_q),
        .grant_o (rr_grant),
        .idx_o   (rr_idx),
        .any_o   (rr_any)
    );

    // Out-of-range fixed selects clamp to the top channel.
    assign fix_sel   = (int'(sel_i) >= NUM_IN) ? SEL_W'(NUM_IN - 1) : sel_i;
    assign is_rr     = (mode_i == MODE_RR);
    assign g         = is_rr ? rr_idx : fix_sel;
    assign has_grant = is_rr ? rr_any : in_valid_i[fix_sel];
    assign load      = rst_n && has_grant && (!out_valid_q || out_ready_i);

    always_comb begin
        in_ready_o  = load ? (is_rr ? rr_grant : (NUM_IN'(1) << fix_sel)) : '0;
        ptr_d       = (load && is_rr) ? ((int'(g) == NUM_IN - 1) ? '0 : g + 1'b1) : ptr_q;
        out_valid_d = load ? 1'b1 : (out_ready_i ? 1'b0 : out_valid_q);
        out_data_d  = load ? in_data_i[g*WIDTH +: WIDTH] : out_data_q;
        out_src_d   = load ? g : out_src_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_src_o   = out_src_q;
    assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: directed checks on 4- and 3-channel instances, randomized scoreboard on a 5-channel, 16-bit instance.
module tb_rr_arb_mux;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        mode4, out_ready4, out_valid4;
    logic [1:0]  sel4, out_src4;
    logic [31:0] in_data4;
    logic [3:0]  in_valid4, in_ready4;
    logic [7:0]  out_data4;

    logic        mode3, out_ready3, out_valid3;
    logic [1:0]  sel3, out_src3;
    logic [23:0] in_data3;
    logic [2:0]  in_valid3, in_ready3;
    logic [7:0]  out_data3;

    logic        mode5, out_ready5, out_valid5;
    logic [2:0]  sel5, out_src5;
    logic [79:0] in_data5;
    logic [4:0]  in_valid5, in_ready5;
    logic [15:0] out_data5;

    rr_arb_mux #(.WIDTH(8), .NUM_IN(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .mode_i(mode4), .sel_i(sel4), .in_data_i(in_data4),
        .in_valid_i(in_valid4), .in_ready_o(in_ready4), .out_data_o(out_data4),
        .out_src_o(out_src4), .out_valid_o(out_valid4), .out_ready_i(out_ready4)
    );

    rr_arb_mux #(.WIDTH(8), .NUM_IN(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode_i(mode3), .sel_i(sel3), .in_data_i(in_data3),
        .in_valid_i(in_valid3), .in_ready_o(in_ready3), .out_data_o(out_data3),
        .out_src_o(out_src3), .out_valid_o(out_valid3), .out_ready_i(out_ready3)
    );

    rr_arb_mux #(.WIDTH(16), .NUM_IN(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .mode_i(mode5), .sel_i(sel5), .in_data_i(in_data5),
        .in_valid_i(in_valid5), .in_ready_o(in_ready5), .out_data_o(out_data5),
        .out_src_o(out_src5), .out_valid_o(out_valid5), .out_ready_i(out_ready5)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model state for the 5-channel instance.
    logic [18:0] sb[$];
    int          m_ptr;
    int          gidx;
    bit          can;
    logic [4:0]  exp_ready;
    logic [18:0] b;

    initial begin
        rst_n = 1'b0;
        mode4 = 1'b1; sel4 = '0; in_valid4 = 4'hF; out_ready4 = 1'b1;
        in_data4 = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b100; out_ready3 = 1'b1;
        in_data3 = {8'h77, 8'h66, 8'h55};
        mode5 = 1'b0; sel5 = '0; in_valid5 = '0; out_ready5 = 1'b0; in_data5 = '0;
        @(negedge clk);
        step;
        step;
        check("rst_valid", 32'(out_valid4), 32'd0);
        check("rst_data", 32'(out_data4), 32'd0);
        check("rst_src", 32'(out_src4), 32'd0);
        check("rst_ready", 32'(in_ready4), 32'd0);

        rst_n = 1'b1;
        #1;
        check("rr_first_ready", 32'(in_ready4), 32'b0001);
        check("clamp_ready", 32'(in_ready3), 32'b100);
        for (int i = 0; i < 5; i++) begin
            step;
            check("rr_seq_src", 32'(out_src4), 32'(i % 4));
            check("rr_seq_data", 32'(out_data4), 32'(8'hA0 + i % 4));
            check("rr_seq_valid", 32'(out_valid4), 32'd1);
        end
        check("clamp_src", 32'(out_src3), 32'd2);
        check("clamp_data", 32'(out_data3), 32'h77);

        out_ready4 = 1'b0;
        #1;
        check("hold_ready0", 32'(in_ready4), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step;
            check("hold_src", 32'(out_src4), 32'd0);
            check("hold_data", 32'(out_data4), 32'hA0);
            check("hold_ready", 32'(in_ready4), 32'd0);
        end
        out_ready4 = 1'b1;
        #1;
        check("hold_ptr_ready", 32'(in_ready4), 32'b0010);
        step;
        check("reload_src", 32'(out_src4), 32'd1);
        check("reload_valid", 32'(out_valid4), 32'd1);

        mode4 = 1'b0; sel4 = 2'd2; in_valid4 = 4'b0100;
        in_data4 = {8'hA3, 8'h5C, 8'hA1, 8'hA0};
        #1;
        check("fix_ready", 32'(in_ready4), 32'b0100);
        step;
        check("fix_data", 32'(out_data4), 32'h5C);
        check("fix_src", 32'(out_src4), 32'd2);
        in_valid4 = 4'b1011;
        #1;
        check("fix_nogrant", 32'(in_ready4), 32'd0);
        step;
        check("fix_drain", 32'(out_valid4), 32'd0);

        mode4 = 1'b1; in_valid4 = 4'b0010;
        #1;
        check("pre_rst_ready", 32'(in_ready4), 32'b0010);
        step;
        check("pre_rst_src", 32'(out_src4), 32'd1);
        out_ready4 = 1'b0; rst_n = 1'b0;
        #1;
        check("in_rst_ready", 32'(in_ready4), 32'd0);
        step;
        check("mid_rst_valid", 32'(out_valid4), 32'd0);
        check("mid_rst_data", 32'(out_data4), 32'd0);
        check("mid_rst_src", 32'(out_src4), 32'd0);
        rst_n = 1'b1; out_ready4 = 1'b1; in_valid4 = 4'b1001;
        #1;
        check("post_rst_ready", 32'(in_ready4), 32'b0001);
        step;
        check("post_rst_src", 32'(out_src4), 32'd0);
        check("post_rst_data", 32'(out_data4), 32'hA0);

        m_ptr = 0;
        for (int i = 0; i < 420; i++) begin
            @(negedge clk);
            check("r_valid", 32'(out_valid5), 32'(sb.size() != 0));
            mode5 = 1'($urandom);
            sel5 = 3'($urandom);
            in_valid5 = (i < 400) ? 5'($urandom) & 5'($urandom | $urandom) : 5'd0;
            out_ready5 = (i < 400) ? ($urandom_range(3) != 0) : 1'b1;
            for (int c = 0; c < 5; c++) in_data5[c*16 +: 16] = 16'($urandom);
            #1;
            can = (sb.size() == 0) || out_ready5;
            gidx = -1;
            if (mode5) begin
                for (int k = 0; k < 5; k++)
                    if (gidx < 0 && in_valid5[(m_ptr + k) % 5]) gidx = (m_ptr + k) % 5;
            end else begin
                gidx = (sel5 > 3'd4) ? 4 : int'(sel5);
                if (!in_valid5[gidx]) gidx = -1;
            end
            exp_ready = (can && gidx >= 0) ? 5'(1 << gidx) : 5'd0;
            check("r_ready", 32'(in_ready5), 32'(exp_ready));
            check("r_onehot", 32'($countones(in_ready5) <= 1), 32'd1);
            if (sb.size() != 0 && out_ready5) begin
                b = sb.pop_front();
                check("r_data", 32'(out_data5), 32'(b[15:0]));
                check("r_src", 32'(out_src5), 32'(b[18:16]));
            end
            if (can && gidx >= 0) begin
                sb.push_back({3'(gidx), in_data5[gidx*16 +: 16]});
                if (mode5) m_ptr = (gidx + 1) % 5;
            end
        end
        @(negedge clk);
        check("r_end_valid", 32'(out_valid5), 32'd0);
        check("r_end_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width per channel.
REQ-002 SHALL have parameter NUM_IN, default 4, input channel count, legal range 2..16.
REQ-003 SHALL have derived constant SEL_W = max(1, clog2(NUM_IN)), not overridable.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-006 mode  input  1  0 = fixed select, 1 = round-robin arbitration.
REQ-007 sel  input  SEL_W  channel index used when mode=0.
REQ-008 in_data  input  NUM_IN*WIDTH  packed channel data; channel i at bits [i*WIDTH +: WIDTH].
REQ-009 in_valid  input  NUM_IN  per-channel valid.
REQ-010 in_ready  output  NUM_IN  per-channel ready; at most one bit high per cycle.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_src  output  SEL_W  index of channel that supplied out_data.
REQ-013 out_valid  output  1  out_data/out_src hold a valid beat.
REQ-014 out_ready  input  1  downstream accepts beat when out_valid and out_ready both high.

Function
REQ-015 Transfer on input i SHALL occur when in_valid[i] and in_ready[i] both high at a rising edge.
REQ-016 Output stage SHALL be one register slot; "load" = (!out_valid || out_ready) and a grant exists.
REQ-017 in_ready SHALL be combinational: in_ready[g]=1 only for granted channel g and only when (!out_valid || out_ready); all others 0.
REQ-018 mode=0: grant channel sel if in_valid[sel]=1, else no grant; sel >= NUM_IN SHALL be treated as NUM_IN-1.
REQ-019 mode=1: grant the first valid channel searching upward from ptr, wrapping NUM_IN-1 -> 0.
REQ-020 ptr (SEL_W bits) SHALL update to (g+1) mod NUM_IN only on a transfer with mode=1; otherwise hold.
REQ-021 On load, out_data<=in_data[g], out_src<=g, out_valid<=1, one-cycle latency input->output.
REQ-022 On out_valid && out_ready with no load, out_valid<=0; out_data/out_src hold.
REQ-023 Simultaneous drain and load SHALL sustain one beat per clock (full throughput, no bubble).
REQ-024 out_valid && !out_ready SHALL hold out_data, out_src, out_valid stable and drive all in_ready low.
REQ-025 Mode or sel change SHALL take effect on the next grant decision; a held output beat is unaffected.
REQ-026 No in_valid asserted: no grant, in_ready all 0, ptr unchanged.
REQ-027 Data SHALL be passed unmodified; no width conversion.

Reset
REQ-028 rst_n=0 at rising edge SHALL set out_valid=0, out_data=0, out_src=0, ptr=0.
REQ-029 Reset mid-transfer SHALL discard the held beat; in_ready SHALL be 0 while rst_n=0.
REQ-030 First grant after reset in mode=1 SHALL search from channel 0.

Structure
REQ-031 Shared package SHALL hold default WIDTH (8), mode encodings MODE_FIXED=0, MODE_RR=1, and the clog2 helper.
REQ-032 Round-robin grant logic SHALL be a sub-module rr_arbiter (inputs req, ptr; outputs one-hot grant, grant index, any_grant).
REQ-033 Select/load/output-register logic SHALL reside in rr_arb_mux; ptr register in rr_arb_mux.

Verification
REQ-034 mode=1, NUM_IN=4, all in_valid=1, out_ready=1, data i=8'hA0+i -> out_src 0,1,2,3,0 on consecutive cycles, no gaps.
REQ-035 mode=0, sel=2, in_valid=4'b0100, in_data ch2=8'h5C -> next cycle out_data=8'h5C, out_src=2; sel=2 with in_valid=4'b1011 -> no grant, in_ready=0.
REQ-036 mode=1, beat held, out_ready=0 for 3 cycles -> out_data/out_src stable, in_ready=0, ptr unchanged; out_ready=1 -> drain and reload same cycle.
REQ-037 mode=0, NUM_IN=3, sel=3, in_valid=3'b100 -> channel 2 granted.
REQ-038 rst_n=0 with out_valid=1, ptr=2 -> next edge out_valid=0, out_data=0, ptr=0; first RR grant with in_valid=4'b1001 selects channel 0.
REQ-039 Random stimulus, WIDTH=16, NUM_IN=5: scoreboard checks every accepted beat appears once, in order, and in_ready never has >1 bit set.
